clock_period_meter: RTL
=======================

# clock_period_meter

Measures an incoming clock-like signal (typically a divided clock produced elsewhere in the design, or an external strobe) against the system clock. Reports, per cycle of the measured signal, its period and high time in `clock_in` cycles, with a one-cycle valid strobe and a timeout flag when the signal stalls. It is the checking end for the team's clock dividers, used for self-test and for frequency readout on the FPGA.

## Interface
- `WIDTH`, 28: width of counters and measurement outputs.
- `TIMEOUT`, 28'd50_000_000: cycles without a rising edge before `timeout` asserts; must satisfy 2 ≤ TIMEOUT ≤ 2^WIDTH−1.
- `clock_in`  input  1  system clock; all logic on its rising edge.
- `reset_n`  input  1  asynchronous, active-low reset.
- `enable`  input  1  synchronous; 1 = measure, 0 = idle.
- `sig_in`  input  1  measured signal, asynchronous to `clock_in`.
- `period`  output  WIDTH  last completed period in `clock_in` cycles.
- `high_time`  output  WIDTH  high time belonging to that period.
- `meas_valid`  output  1  one-cycle pulse when `period`/`high_time` update.
- `timeout`  output  1  level; signal stalled.

## Operation
- Input path: `sig_in` → sync flop s1 → sync flop s2 → history flop s3.
  - rise = s2 & ~s3; fall = ~s2 & s3.
  - All three flops reset to 0.
- Counter `cnt` (WIDTH bits) counts `clock_in` cycles since the last detected rise.
- `hi_cnt` holds the high time captured at the last fall.
- States:
  - IDLE (reset state):
    - `cnt` = 0; `timeout` cleared.
    - `enable`=1 → ARM.
  - ARM: wait for the first rise.
    - On rise: `cnt` <= 0, `hi_cnt` <= 0, go to MEASURE.
    - No output update; `timeout` holds its value.
  - MEASURE: `cnt` <= `cnt`+1 every cycle, except as listed below.
    - On fall: `hi_cnt` <= `cnt`+1.
    - On rise:
      - `period` <= `cnt`+1; `high_time` <= `hi_cnt`.
      - `meas_valid` <= 1; `timeout` <= 0.
      - `cnt` <= 0; stay in MEASURE.
    - Timeout: if `cnt` = TIMEOUT−1 and no rise this cycle → `timeout` <= 1, state → ARM, `cnt` <= 0.
- `enable`=0 in any state → IDLE on the next edge.
  - `period` and `high_time` hold their values.
  - `meas_valid` = 0; `timeout` <= 0.
- Rise and fall cannot coincide, because s2 is a single bit.
- If a period sees no fall (signal stuck high and then only rises are seen), `high_time` reports the stale `hi_cnt`. This is acceptable; a timeout covers the stuck case.
- The first `meas_valid` after entering MEASURE is at the second detected rise. A partial first period is never reported.
- Minimum measurable period is 2 cycles; minimum high/low time is 1 cycle. Shorter pulses may be missed; nothing further is specified for them.

## Timing
- Reset values:
  - `period` = 0, `high_time` = 0.
  - `meas_valid` = 0, `timeout` = 0.
  - state = IDLE.
- Latency: a `sig_in` rise first sampled by s1 at edge k is detected as a rise in the cycle after edge k+1. `period`/`high_time`/`meas_valid` update at edge k+2.
- For a `sig_in` synchronous to `clock_in` with period P and high time H, steady-state reports are exactly `period` = P and `high_time` = H, one `meas_valid` per P cycles.
- `meas_valid` is never high for two consecutive cycles.
- `timeout` asserts exactly TIMEOUT cycles after the last rise was detected in MEASURE.
- `reset_n` low mid-measurement immediately forces all reset values. After release, the block restarts from IDLE.

## Test plan
- Reset: hold `reset_n`=0 for 5 cycles with `sig_in` toggling → all outputs 0; after release with `enable`=0 → no `meas_valid`.
- Steady clock: `enable`=1, `sig_in` synchronous with period 10 and high 4 → first `meas_valid` at the second rise, then every 10 cycles, with `period`=10 and `high_time`=4.
- Fastest input: `sig_in` with period 2 and high 1 → `meas_valid` every 2 cycles, `period`=2, `high_time`=1.
- Timeout: TIMEOUT=20, period-8 signal, then hold `sig_in` low → `timeout`=1 exactly 20 cycles after the last detected rise, with `period` holding 8. Restart with a period-6 signal → `timeout` clears on the first new `meas_valid` (second rise), and `period`=6.
- Enable drop: deassert `enable` mid-period → no `meas_valid`, outputs hold, `timeout`=0. Re-enable → first report at the second subsequent rise.
- Mid-operation reset: pulse `reset_n` low between edges during MEASURE → outputs clear asynchronously, and the next report follows the ARM sequence.

Source files
------------

// File: rtl/clock_period_meter_if.sv
// Bundle of the measurement signals of clock_period_meter.
//   enable     : 1 = measure, 0 = idle (synchronous to clock_in)
//   sig_in     : measured signal, asynchronous to clock_in
//   period     : last completed period in clock_in cycles
//   high_time  : high time belonging to that period
//   meas_valid : one-cycle pulse when period/high_time update
//   timeout    : level, measured signal has stalled
// master drives enable/sig_in; slave (the meter) drives the results.
interface clock_period_meter_if #(
  parameter int unsigned WIDTH = 28
);
  logic             enable;
  logic             sig_in;
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] high_time;
  logic             meas_valid;
  logic             timeout;

  modport master (
    output enable, sig_in,
    input  period, high_time, meas_valid, timeout
  );

  modport slave (
    input  enable, sig_in,
    output period, high_time, meas_valid, timeout
  );
endinterface

// File: rtl/clock_period_meter.sv
// Measures period and high time of sig_in in clock_in cycles.
//   clock_in : system clock, all logic on its rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : clock_period_meter_if slave (enable, sig_in in;
//              period, high_time, meas_valid, timeout out)
// sig_in passes two synchroniser flops plus a history flop; edges are
// detected on the synchronised copy. A report is produced on every
// detected rise after the first one seen since arming.
module clock_period_meter #(
  parameter int unsigned      WIDTH   = 28,
  parameter logic [WIDTH-1:0] TIMEOUT = 28'd50_000_000
) (
  input  logic                 clock_in,
  input  logic                 reset_n,
  clock_period_meter_if.slave  bus
);

  localparam logic [WIDTH-1:0] TO_LAST = TIMEOUT - WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEASURE
  } state_t;

  state_t           state_q, state_d;
  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             s3_q, s3_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_cnt_q, hi_cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] high_time_q, high_time_d;
  logic             meas_valid_q, meas_valid_d;
  logic             timeout_q, timeout_d;

  logic             rise;
  logic             fall;
  logic [WIDTH-1:0] cnt_inc;

  always_comb begin
    s1_d = bus.sig_in;
    s2_d = s1_q;
    s3_d = s2_q;

    rise    = s2_q & ~s3_q;
    fall    = ~s2_q & s3_q;
    cnt_inc = cnt_q + WIDTH'(1);

    state_d      = state_q;
    cnt_d        = cnt_q;
    hi_cnt_d     = hi_cnt_q;
    period_d     = period_q;
    high_time_d  = high_time_q;
    meas_valid_d = 1'b0;
    timeout_d    = timeout_q;

    if (!bus.enable) begin
      state_d   = IDLE;
      cnt_d     = '0;
      timeout_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d     = '0;
          timeout_d = 1'b0;
          state_d   = ARM;
        end
        ARM: begin
          // First rise only starts the count; a partial period is never reported.
          if (rise) begin
            cnt_d    = '0;
            hi_cnt_d = '0;
            state_d  = MEASURE;
          end
        end
        MEASURE: begin
          if (rise) begin
            period_d     = cnt_inc;
            high_time_d  = hi_cnt_q;
            meas_valid_d = 1'b1;
            timeout_d    = 1'b0;
            cnt_d        = '0;
          end else if (cnt_q == TO_LAST) begin
            timeout_d = 1'b1;
            cnt_d     = '0;
            state_d   = ARM;
          end else begin
            cnt_d = cnt_inc;
            if (fall) begin
              hi_cnt_d = cnt_inc;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      s3_q         <= 1'b0;
      cnt_q        <= '0;
      hi_cnt_q     <= '0;
      period_q     <= '0;
      high_time_q  <= '0;
      meas_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      s3_q         <= s3_d;
      cnt_q        <= cnt_d;
      hi_cnt_q     <= hi_cnt_d;
      period_q     <= period_d;
      high_time_q  <= high_time_d;
      meas_valid_q <= meas_valid_d;
      timeout_q    <= timeout_d;
    end
  end

  assign bus.period     = period_q;
  assign bus.high_time  = high_time_q;
  assign bus.meas_valid = meas_valid_q;
  assign bus.timeout    = timeout_q;

endmodule
